riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- lsu_req_i  in  1  core requests a memory access (decoder mem_req)
- lsu_we_i  in  1  1 = store, 0 = load (decoder mem_we)
- lsu_size_i  in  3  access size/sign, funct3 encoding (decoder mem_size)
- lsu_addr_i  in  32  byte address from ALU
- lsu_data_i  in  32  store data (rs2)
- lsu_data_o  out  32  extended load result
- lsu_stall_o  out  1  core must hold its current instruction
- lsu_err_o  out  1  misaligned or illegal size, one-cycle pulse
- data_req_o  out  1  memory request
- data_we_o  out  1  memory write
- data_be_o  out  4  byte enables
- data_addr_o  out  32  memory byte address
- data_wdata_o  out  32  lane-replicated store data
- data_rdata_i  in  32  memory read word
- data_ready_i  in  1  memory completes the held request this cycle
REQ-002 SHALL use one clock and an asynchronous, active-high reset; no other clocks or resets.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-004 IDLE: if lsu_req_i=1, SHALL assert lsu_stall_o combinationally that cycle and register addr/we/size/wdata.
REQ-005 IDLE, request legal and aligned -> BUSY; illegal or misaligned -> RESP with error flag set, no memory access.
REQ-006 Legal sizes SHALL be B=000, H=001, W=010, BU=100, HU=101; any other value is illegal; BU/HU with lsu_we_i=1 is illegal.
REQ-007 Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00; B/BU are always aligned.
REQ-008 BUSY: data_req_o=1 with data_we_o/data_be_o/data_addr_o/data_wdata_o held stable until data_ready_i=1; lsu_stall_o=1 throughout.
REQ-009 BUSY with data_ready_i=1: loads SHALL capture data_rdata_i, shifted and extended, into the lsu_data_o register; next state RESP.
REQ-010 RESP: lsu_stall_o=0 for exactly one cycle, lsu_data_o valid, lsu_err_o=1 only for an error access; next state IDLE; lsu_req_i ignored in RESP.
REQ-011 Byte enables: B = 0001 shifted by addr[1:0]; H = 0011 shifted by 2*addr[1]; W = 1111.
REQ-012 Store data: B = {4{d[7:0]}}, H = {2{d[15:0]}}, W = d.
REQ-013 Load extraction: byte at lane addr[1:0], half at lane addr[1]; B/H sign-extend, BU/HU zero-extend to 32 bits.
REQ-014 Latency with data_ready_i=1 on the first BUSY cycle: request cycle N, data_req_o cycle N+1, RESP (stall low) cycle N+2.
REQ-015 lsu_data_o SHALL hold its value until the next load completes; stores and errors leave it unchanged.
REQ-016 Outside BUSY, data_req_o=0 and data_we_o=0.

Reset
REQ-017 On rst_i=1 the FSM SHALL enter IDLE immediately, including mid-BUSY; outputs: lsu_data_o=0, lsu_err_o=0, data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
REQ-018 An access interrupted by reset SHALL be dropped; no response is produced after reset release.

Structure
REQ-019 Shared package riscv_pkg SHALL hold LDST_B/H/W/BU/HU constants and the LSU state encoding.
REQ-020 Load lane selection and extension SHALL be a combinational sub-module riscv_lsu_extend.

Verification
REQ-021 LB addr=0x103, rdata=0x80FF_0000, ready first cycle -> be=1000, lsu_data_o=0xFFFFFF80, stall high 2 cycles.
REQ-022 SH addr=0x22, data=0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, lsu_data_o unchanged.
REQ-023 LW addr=0x41 -> no data_req_o, lsu_err_o pulse in RESP, stall released after 1 cycle.
REQ-024 LHU addr=0x10, ready after 3 BUSY cycles, rdata=0x0000F00D -> outputs stable while waiting, lsu_data_o=0x0000F00D.
REQ-025 rst_i asserted mid-BUSY -> data_req_o=0 immediately, IDLE, no RESP pulse after release.
REQ-026 size=011 load -> lsu_err_o=1, no memory access.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared LSU definitions: funct3 access sizes, FSM encoding,
// the latched request bundle and the size/lane helper functions.
package riscv_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUSY = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic lsu_size_ok(
      input logic [2:0] size,
      input logic       we
   );
      logic ok;
      case (size)
         LDST_B, LDST_H, LDST_W: ok = 1'b1;
         LDST_BU, LDST_HU:       ok = !we;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic lsu_aligned(
      input logic [2:0] size,
      input logic [1:0] addr_lo
   );
      logic ok;
      case (size)
         LDST_H, LDST_HU: ok = !addr_lo[0];
         LDST_W:          ok = (addr_lo == 2'b00);
         default:         ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lsu_be(
      input logic [2:0] size,
      input logic [1:0] addr_lo
   );
      logic [3:0] be;
      case (size)
         LDST_B, LDST_BU: be = 4'b0001 << addr_lo;
         LDST_H, LDST_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         LDST_W:          be = 4'b1111;
         default:         be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lsu_wdata(
      input logic [2:0]  size,
      input logic [31:0] d
   );
      logic [31:0] w;
      case (size)
         LDST_B:  w = {4{d[7:0]}};
         LDST_H:  w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/riscv_lsu_extend.sv
// Load lane select: picks the addressed byte/half from the
// memory word and sign- or zero-extends it to 32 bits.
module riscv_lsu_extend
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] data_o
);

   logic [7:0]  b_lane;
   logic [15:0] h_lane;

   always_comb begin
      b_lane = rdata_i[7:0];
      unique case (addr_lo_i)
         2'd0: b_lane = rdata_i[7:0];
         2'd1: b_lane = rdata_i[15:8];
         2'd2: b_lane = rdata_i[23:16];
         2'd3: b_lane = rdata_i[31:24];
         default: b_lane = rdata_i[7:0];
      endcase
      h_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o = rdata_i;
      case (size_i)
         LDST_B:  data_o = {{24{b_lane[7]}}, b_lane};
         LDST_BU: data_o = {24'd0, b_lane};
         LDST_H:  data_o = {{16{h_lane[15]}}, h_lane};
         LDST_HU: data_o = {16'd0, h_lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: latches the core request,
// runs one memory handshake and returns a one-cycle response.
module riscv_lsu
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_o,
   output logic        lsu_err_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   input  logic        data_ready_i
);

   lsu_state_e  state_q;
   lsu_state_e  state_d;
   lsu_req_t    req_q;
   logic        err_q;
   logic [31:0] data_q;
   logic [31:0] ext_data;
   logic        legal;
   logic        capture;
   logic        load_done;

   assign legal = lsu_size_ok(lsu_size_i, lsu_we_i) &&
                  lsu_aligned(lsu_size_i, lsu_addr_i[1:0]);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= LSU_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      lsu_stall_o = 1'b0;
      data_req_o  = 1'b0;
      capture     = 1'b0;
      load_done   = 1'b0;
      unique case (state_q)
         LSU_IDLE: begin
            if (lsu_req_i) begin
               lsu_stall_o = 1'b1;
               capture     = 1'b1;
               state_d     = legal ? LSU_BUSY : LSU_RESP;
            end
         end
         LSU_BUSY: begin
            lsu_stall_o = 1'b1;
            data_req_o  = 1'b1;
            if (data_ready_i) begin
               load_done = !req_q.we;
               state_d   = LSU_RESP;
            end
         end
         LSU_RESP: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   // Lane encoding is done once at capture so BUSY outputs are flops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q  <= '0;
         err_q  <= 1'b0;
         data_q <= '0;
      end else begin
         if (capture) begin
            req_q <= '{
               we:    lsu_we_i,
               size:  lsu_size_i,
               addr:  lsu_addr_i,
               be:    lsu_be(lsu_size_i, lsu_addr_i[1:0]),
               wdata: lsu_wdata(lsu_size_i, lsu_data_i)
            };
            err_q <= !legal;
         end
         if (load_done) data_q <= ext_data;
      end
   end

   riscv_lsu_extend u_extend (
      .rdata_i   (data_rdata_i),
      .size_i    (req_q.size),
      .addr_lo_i (req_q.addr[1:0]),
      .data_o    (ext_data)
   );

   assign data_we_o    = data_req_o & req_q.we;
   assign data_be_o    = data_req_o ? req_q.be    : 4'b0000;
   assign data_addr_o  = data_req_o ? req_q.addr  : 32'd0;
   assign data_wdata_o = data_req_o ? req_q.wdata : 32'd0;
   assign lsu_err_o    = (state_q == LSU_RESP) & err_q;
   assign lsu_data_o   = data_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table, a reset-abort
// sequence and random accesses against a reference model.
module tb_riscv_lsu;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_o;
   logic        lsu_err_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i;
   logic        data_ready_i;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   riscv_lsu dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .lsu_req_i    (lsu_req_i),
      .lsu_we_i     (lsu_we_i),
      .lsu_size_i   (lsu_size_i),
      .lsu_addr_i   (lsu_addr_i),
      .lsu_data_i   (lsu_data_i),
      .lsu_data_o   (lsu_data_o),
      .lsu_stall_o  (lsu_stall_o),
      .lsu_err_o    (lsu_err_o),
      .data_req_o   (data_req_o),
      .data_we_o    (data_we_o),
      .data_be_o    (data_be_o),
      .data_addr_o  (data_addr_o),
      .data_wdata_o (data_wdata_o),
      .data_rdata_i (data_rdata_i),
      .data_ready_i (data_ready_i)
   );

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      logic        exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      int          exp_stall;
   } vec_t;

   typedef struct {
      int          stall;
      int          busy;
      logic        err;
      logic        err_early;
      logic        err_after;
      logic        stall_after;
      logic        req_idle;
      logic        unstable;
      logic        timeout;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
   } obs_t;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, output obs_t o);
      int cyc;
      o = '{default: '0};
      @(negedge clk);
      lsu_req_i    = 1'b1;
      lsu_we_i     = v.we;
      lsu_size_i   = v.size;
      lsu_addr_i   = v.addr;
      lsu_data_i   = v.wdata;
      data_rdata_i = v.rdata;
      data_ready_i = 1'b0;
      cyc = 0;
      o.timeout = 1'b1;
      while (cyc < 30) begin
         #1;
         if (!lsu_stall_o) begin
            o.timeout = 1'b0;
            break;
         end
         if (lsu_err_o) o.err_early = 1'b1;
         if (cyc == 0 && data_req_o) o.req_idle = 1'b1;
         if (cyc > 0 && data_req_o) begin
            if (o.busy == 0) begin
               o.we    = data_we_o;
               o.be    = data_be_o;
               o.addr  = data_addr_o;
               o.wdata = data_wdata_o;
            end else if (o.we !== data_we_o || o.be !== data_be_o ||
                         o.addr !== data_addr_o ||
                         o.wdata !== data_wdata_o) begin
               o.unstable = 1'b1;
            end
            o.busy++;
            data_ready_i = (o.busy > v.lat);
         end
         o.stall++;
         @(negedge clk);
         data_ready_i = 1'b0;
         cyc++;
      end
      o.err  = lsu_err_o;
      o.data = lsu_data_o;
      if (data_req_o) o.unstable = 1'b1;
      lsu_req_i = 1'b0;
      @(negedge clk);
      #1;
      o.err_after   = lsu_err_o;
      o.stall_after = lsu_stall_o | data_req_o;
   endtask

   task automatic check_txn(input string tag, input vec_t v,
                            input obs_t o);
      chk({tag, ".timeout"}, 32'(o.timeout), 32'd0);
      chk({tag, ".stall"}, o.stall, v.exp_stall);
      chk({tag, ".err"}, 32'(o.err), 32'(v.exp_err));
      chk({tag, ".data"}, o.data, v.exp_data);
      chk({tag, ".busy"}, o.busy, v.exp_err ? 0 : v.lat + 1);
      chk({tag, ".err_early"}, 32'(o.err_early), 32'd0);
      chk({tag, ".err_after"}, 32'(o.err_after), 32'd0);
      chk({tag, ".idle_after"}, 32'(o.stall_after), 32'd0);
      chk({tag, ".req_idle"}, 32'(o.req_idle), 32'd0);
      if (!v.exp_err) begin
         chk({tag, ".we"}, 32'(o.we), 32'(v.we));
         chk({tag, ".be"}, 32'(o.be), 32'(v.exp_be));
         chk({tag, ".addr"}, o.addr, v.addr);
         chk({tag, ".stable"}, 32'(o.unstable), 32'd0);
         if (v.we) chk({tag, ".wdata"}, o.wdata, v.exp_wdata);
      end
   endtask

   // Reference model from the access rules, using plain arithmetic.
   function automatic vec_t model(input vec_t v,
                                  input logic [31:0] last);
      int nbytes;
      int ofs;
      logic legal;
      longint val;
      vec_t r;
      r = v;
      ofs = int'(v.addr % 4);
      nbytes = (v.size == 3'd2) ? 4 : ((v.size % 4 == 1) ? 2 : 1);
      legal = (v.size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
              !(v.we && v.size >= 3'd4);
      if (nbytes == 2 && ofs % 2 != 0) legal = 1'b0;
      if (nbytes == 4 && ofs != 0) legal = 1'b0;
      r.exp_err   = !legal;
      r.exp_stall = legal ? v.lat + 2 : 1;
      r.exp_be    = 4'(((1 << nbytes) - 1) << ofs);
      if (nbytes == 1)      r.exp_wdata = (v.wdata % 256) * 32'h01010101;
      else if (nbytes == 2) r.exp_wdata = (v.wdata % 65536) * 32'h00010001;
      else                  r.exp_wdata = v.wdata;
      r.exp_data = last;
      if (legal && !v.we) begin
         val = longint'(v.rdata >> (8 * ofs));
         if (nbytes < 4) begin
            val = val % (64'd1 << (8 * nbytes));
            if (v.size < 3'd4 && val >= (64'd1 << (8 * nbytes - 1)))
               val = val - (64'd1 << (8 * nbytes));
         end
         r.exp_data = val[31:0];
      end
      return r;
   endfunction

   vec_t tbl[13];
   vec_t rv;
   obs_t ob;
   logic [31:0] last_data;

   initial begin
      tbl[0]  = '{1'b0, LDST_B,  32'h103, 32'h0,      32'h80FF0000, 0,
                  1'b0, 4'b1000, 32'h0,      32'hFFFFFF80, 2};
      tbl[1]  = '{1'b1, LDST_H,  32'h22,  32'h1234ABCD, 32'h0,      0,
                  1'b0, 4'b1100, 32'hABCDABCD, 32'hFFFFFF80, 2};
      tbl[2]  = '{1'b0, LDST_W,  32'h41,  32'h0,      32'h0,        0,
                  1'b1, 4'b0000, 32'h0,      32'hFFFFFF80, 1};
      tbl[3]  = '{1'b0, LDST_HU, 32'h10,  32'h0,      32'h0000F00D, 3,
                  1'b0, 4'b0011, 32'h0,      32'h0000F00D, 5};
      tbl[4]  = '{1'b0, 3'b011,  32'h0,   32'h0,      32'h12345678, 0,
                  1'b1, 4'b0000, 32'h0,      32'h0000F00D, 1};
      tbl[5]  = '{1'b0, LDST_W,  32'h200, 32'h0,      32'hDEADBEEF, 1,
                  1'b0, 4'b1111, 32'h0,      32'hDEADBEEF, 3};
      tbl[6]  = '{1'b0, LDST_H,  32'h2,   32'h0,      32'h80011234, 0,
                  1'b0, 4'b1100, 32'h0,      32'hFFFF8001, 2};
      tbl[7]  = '{1'b1, LDST_B,  32'h1,   32'h000000A5, 32'h0,      2,
                  1'b0, 4'b0010, 32'hA5A5A5A5, 32'hFFFF8001, 4};
      tbl[8]  = '{1'b1, LDST_BU, 32'h0,   32'h11,     32'h0,        0,
                  1'b1, 4'b0000, 32'h0,      32'hFFFF8001, 1};
      tbl[9]  = '{1'b0, LDST_BU, 32'h2,   32'h0,      32'h00AB0000, 0,
                  1'b0, 4'b0100, 32'h0,      32'h000000AB, 2};
      tbl[10] = '{1'b1, LDST_W,  32'h3,   32'h5,      32'h0,        0,
                  1'b1, 4'b0000, 32'h0,      32'h000000AB, 1};
      tbl[11] = '{1'b1, LDST_H,  32'h1,   32'h5,      32'h0,        0,
                  1'b1, 4'b0000, 32'h0,      32'h000000AB, 1};
      tbl[12] = '{1'b0, LDST_B,  32'h0,   32'h0,      32'h1234567F, 0,
                  1'b0, 4'b0001, 32'h0,      32'h0000007F, 2};

      rst_i        = 1'b1;
      lsu_req_i    = 1'b0;
      lsu_we_i     = 1'b0;
      lsu_size_i   = 3'd0;
      lsu_addr_i   = 32'd0;
      lsu_data_i   = 32'd0;
      data_rdata_i = 32'd0;
      data_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.data", lsu_data_o, 32'd0);
      chk("rst.err", 32'(lsu_err_o), 32'd0);
      chk("rst.req", 32'(data_req_o), 32'd0);
      chk("rst.be", 32'(data_be_o), 32'd0);
      chk("rst.addr", data_addr_o, 32'd0);
      chk("rst.wdata", data_wdata_o, 32'd0);
      rst_i = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_txn(tbl[i], ob);
         check_txn($sformatf("vec%0d", i), tbl[i], ob);
      end

      // Abort a load that is waiting on memory.
      @(negedge clk);
      lsu_req_i    = 1'b1;
      lsu_we_i     = 1'b0;
      lsu_size_i   = LDST_W;
      lsu_addr_i   = 32'h100;
      data_rdata_i = 32'hCAFEF00D;
      #1 chk("abort.stall_idle", 32'(lsu_stall_o), 32'd1);
      @(negedge clk);
      lsu_req_i = 1'b0;
      #1 chk("abort.busy1", 32'(data_req_o), 32'd1);
      @(negedge clk);
      #1 chk("abort.busy2", 32'(data_req_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("abort.req", 32'(data_req_o), 32'd0);
      chk("abort.we", 32'(data_we_o), 32'd0);
      chk("abort.be", 32'(data_be_o), 32'd0);
      chk("abort.addr", data_addr_o, 32'd0);
      chk("abort.data", lsu_data_o, 32'd0);
      chk("abort.stall", 32'(lsu_stall_o), 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      data_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("abort.no_resp", {30'd0, lsu_err_o, lsu_stall_o}, 32'd0);
         chk("abort.no_req", 32'(data_req_o), 32'd0);
         chk("abort.no_load", lsu_data_o, 32'd0);
      end
      data_ready_i = 1'b0;

      last_data = 32'd0;
      for (int i = 0; i < 300; i++) begin
         rv = '{default: '0};
         rv.we    = 1'($urandom_range(0, 1));
         rv.size  = 3'($urandom_range(0, 7));
         rv.addr  = $urandom;
         rv.wdata = $urandom;
         rv.rdata = $urandom;
         rv.lat   = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) begin
            if (rv.size == LDST_W) rv.addr[1:0] = 2'b00;
            else rv.addr[0] = rv.addr[0] & rv.size[1];
         end
         rv = model(rv, last_data);
         run_txn(rv, ob);
         check_txn($sformatf("rnd%0d", i), rv, ob);
         last_data = rv.exp_data;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
